// File: rtl/pe_drain_ctrl_if.sv
// Result stream from the drain controller to its consumer.
interface pe_drain_ctrl_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/pe_drain_ctrl.sv
// Drains the accumulated results of a PE row tail-first onto a valid/ready
// stream, shifting the chain once per accepted byte with zeros fed in at the
// head so the row is left cleared.
module pe_drain_ctrl #(
    parameter int unsigned N_PE   = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              chain_en_o,
    output logic [DATA_W-1:0] chain_head_o,
    input  logic [DATA_W-1:0] chain_tail_i,
    pe_drain_ctrl_if.master   out_if
);
    localparam int unsigned     CntW    = (N_PE > 1) ? $clog2(N_PE) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(N_PE - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StValid,
        StShift,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              cnt_is_last;

    assign cnt_is_last = (cnt_q == LastIdx);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one capture / present / shift round per element
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_i) state_d = StCapture;
            StCapture: state_d = StValid;
            StValid:   if (out_if.ready) state_d = StShift;
            StShift:   state_d = cnt_is_last ? StDone : StCapture;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath next-state: element counter, captured byte, last flag, done pulse
    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        last_d = last_q;
        done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) cnt_d = '0;
            end
            StCapture: begin
                data_d = chain_tail_i;
                last_d = cnt_is_last;
            end
            StShift: begin
                // The shift out of the final element is the one that empties the row
                if (cnt_is_last) begin
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                cnt_d = '0;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
            last_q <= last_d;
            done_q <= done_d;
        end
    end

    // Outputs decoded from state plus registered datapath
    always_comb begin
        busy_o       = (state_q != StIdle);
        chain_en_o   = (state_q == StShift);
        chain_head_o = '0;
        done_o       = done_q;
        out_if.valid = (state_q == StValid);
        out_if.data  = data_q;
        out_if.last  = last_q;
    end
endmodule

// File: tb/tb_pe_drain_ctrl.sv
// Bench for pe_drain_ctrl: a 4-PE build driven by a timing table, directed
// corner sequences and random backpressure, plus a 1-PE build.
module tb_pe_drain_ctrl;
    localparam int unsigned N4 = 4;
    localparam int unsigned DW = 8;
    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start, busy, done, chain_en;
    logic [DW-1:0] chain_head, chain_tail;
    logic          start1, busy1, done1, ce1;
    logic [DW-1:0] head1, tail1;

    pe_drain_ctrl_if #(.DATA_W(DW)) s_if ();
    pe_drain_ctrl_if #(.DATA_W(DW)) s1_if ();

    pe_drain_ctrl #(.N_PE(N4), .DATA_W(DW)) dut4 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .chain_en_o(chain_en), .chain_head_o(chain_head), .chain_tail_i(chain_tail),
        .out_if(s_if)
    );

    pe_drain_ctrl #(.N_PE(1), .DATA_W(DW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .chain_en_o(ce1), .chain_head_o(head1), .chain_tail_i(tail1),
        .out_if(s1_if)
    );

    // Behavioural PE rows: index 0 is the head, the last index is the tail.
    logic [DW-1:0] chain4 [N4];
    logic [DW-1:0] pre4   [N4];
    logic [DW-1:0] chain1, pre1;
    bit            load4, load1;

    always @(posedge clk) begin
        if (load4) begin
            chain4 <= pre4;
        end else if (chain_en) begin
            for (int i = int'(N4) - 1; i > 0; i--) chain4[i] <= chain4[i-1];
            chain4[0] <= chain_head;
        end
        if (load1) chain1 <= pre1;
        else if (ce1) chain1 <= head1;
    end
    assign chain_tail = chain4[N4-1];
    assign tail1      = chain1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Stream monitor: samples just after the negative edge, once the inputs for
    // the coming rising edge are in place.
    logic [DW:0]   rx_q [$];
    int            ce_cnt, done_cnt;
    bit            prev_hs, prev_valid, prev_ready, prev_last;
    logic [DW-1:0] prev_data;

    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            prev_hs    = 1'b0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (chain_en) begin
                ce_cnt++;
                chk("chain_en_follows_accept", 32'(prev_hs), 1);
            end
            if (done) done_cnt++;
            if (s_if.valid && prev_valid && !prev_ready) begin
                chk("stall_data_stable", 32'(s_if.data), 32'(prev_data));
                chk("stall_last_stable", 32'(s_if.last), 32'(prev_last));
            end
            if (s_if.valid && s_if.ready) rx_q.push_back({s_if.last, s_if.data});
            prev_hs    = s_if.valid && s_if.ready;
            prev_valid = s_if.valid;
            prev_ready = s_if.ready;
            prev_data  = s_if.data;
            prev_last  = s_if.last;
        end
    end

    // Reference: bytes leave tail-first, exactly as the row held them at start.
    logic [DW-1:0] exp_q [$];

    function automatic void exp_from_model();
        exp_q.delete();
        for (int i = int'(N4) - 1; i >= 0; i--) exp_q.push_back(chain4[i]);
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        ce_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic preload(input logic [DW-1:0] h0, h1, h2, h3);
        @(negedge clk);
        pre4[0] = h0;
        pre4[1] = h1;
        pre4[2] = h2;
        pre4[3] = h3;
        load4   = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
    endtask

    task automatic check_result();
        chk("byte_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            chk("byte_data", 32'(rx_q[i][DW-1:0]), 32'(exp_q[i]));
            chk("byte_last", 32'(rx_q[i][DW]), (i == exp_q.size() - 1) ? 1 : 0);
        end
        chk("chain_en_pulses", ce_cnt, N4);
        chk("done_pulses", done_cnt, 1);
        for (int i = 0; i < int'(N4); i++) chk("row_cleared", 32'(chain4[i]), 0);
    endtask

    // Full drain from a negedge; optional stall on one byte, a start pulse
    // during one byte, or random ready/start.
    task automatic drain(input int stall_byte, input int stall_len, input int restart_byte,
                         input bit rnd);
        int b    = 0;
        int held = 0;
        bit fin  = 1'b0;
        clear_mon();
        start       = 1'b1;
        s_if.ready  = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 0) begin
                chk("start_busy", 32'(busy), 1);
                chk("start_capture_not_valid", 32'(s_if.valid), 0);
            end
            if (done) begin
                fin = 1'b1;
            end else if (s_if.valid) begin
                if (b == stall_byte && held < stall_len) begin
                    if (held > 0 && b < exp_q.size()) begin
                        chk("stall_data", 32'(s_if.data), 32'(exp_q[b]));
                        chk("stall_chain_en", 32'(chain_en), 0);
                    end
                    s_if.ready = 1'b0;
                    held++;
                end else begin
                    s_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (b == restart_byte) start = 1'b1;
                if (s_if.ready) b++;
            end else begin
                s_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (rnd && !fin && $urandom_range(0, 7) == 0) start = 1'b1;
        end
        chk("drain_completes", 32'(fin), 1);
        start      = 1'b0;
        s_if.ready = 1'b0;
        @(negedge clk);
        chk("idle_after_done", 32'(busy), 0);
        check_result();
    endtask

    typedef struct {
        bit            start;
        bit            ready;
        bit            busy;
        bit            valid;
        bit            ce;
        bit            done;
        bit            last;
        logic [DW-1:0] data;
    } vec_t;

    function automatic vec_t v(bit s, bit r, bit bz, bit vl, bit c, bit d, bit l,
                               logic [DW-1:0] dt);
        vec_t x;
        x.start = s;
        x.ready = r;
        x.busy  = bz;
        x.valid = vl;
        x.ce    = c;
        x.done  = d;
        x.last  = l;
        x.data  = dt;
        return x;
    endfunction

    vec_t tbl [14];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb, ce1n, dn1;
        bit fin1;
        rst_n       = 1'b0;
        start       = 1'b0;
        start1      = 1'b0;
        s_if.ready  = 1'b0;
        s1_if.ready = 1'b0;
        load4       = 1'b0;
        load1       = 1'b0;
        pre1        = '0;
        for (int i = 0; i < int'(N4); i++) pre4[i] = '0;
        clear_mon();
        repeat (3) @(negedge clk);

        chk("reset_busy", 32'(busy), 0);
        chk("reset_valid", 32'(s_if.valid), 0);
        chk("reset_chain_en", 32'(chain_en), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_data", 32'(s_if.data), 0);
        chk("reset_last", 32'(s_if.last), 0);
        chk("reset_head_zero", 32'(chain_head), 0);
        chk("reset_busy_n1", 32'(busy1), 0);
        rst_n = 1'b1;

        // Ready always high: cycle-exact timing from the start edge onward.
        tbl[0]  = v(H, H, H, L, L, L, L, 8'h00);
        tbl[1]  = v(L, H, H, H, L, L, L, 8'h11);
        tbl[2]  = v(L, H, H, L, H, L, L, 8'h00);
        tbl[3]  = v(L, H, H, L, L, L, L, 8'h00);
        tbl[4]  = v(L, H, H, H, L, L, L, 8'h22);
        tbl[5]  = v(L, H, H, L, H, L, L, 8'h00);
        tbl[6]  = v(L, H, H, L, L, L, L, 8'h00);
        tbl[7]  = v(L, H, H, H, L, L, L, 8'h33);
        tbl[8]  = v(L, H, H, L, H, L, L, 8'h00);
        tbl[9]  = v(L, H, H, L, L, L, L, 8'h00);
        tbl[10] = v(L, H, H, H, L, L, H, 8'h44);
        tbl[11] = v(L, H, H, L, H, L, L, 8'h00);
        tbl[12] = v(L, H, H, L, L, H, L, 8'h00);
        tbl[13] = v(L, H, L, L, L, L, L, 8'h00);
        preload(8'h44, 8'h33, 8'h22, 8'h11);
        exp_from_model();
        clear_mon();
        for (int i = 0; i < 14; i++) begin
            start      = tbl[i].start;
            s_if.ready = tbl[i].ready;
            @(negedge clk);
            chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
            chk("tbl_valid", 32'(s_if.valid), 32'(tbl[i].valid));
            chk("tbl_chain_en", 32'(chain_en), 32'(tbl[i].ce));
            chk("tbl_done", 32'(done), 32'(tbl[i].done));
            if (tbl[i].valid) begin
                chk("tbl_data", 32'(s_if.data), 32'(tbl[i].data));
                chk("tbl_last", 32'(s_if.last), 32'(tbl[i].last));
            end
        end
        start      = 1'b0;
        s_if.ready = 1'b0;
        check_result();

        // Five-cycle stall on byte 1.
        preload(8'h44, 8'h33, 8'h22, 8'h11);
        exp_from_model();
        drain(1, 5, -1, 1'b0);

        // Start pulsed again during byte 2 must not restart or queue.
        preload(8'h44, 8'h33, 8'h22, 8'h11);
        exp_from_model();
        drain(-1, 0, 2, 1'b0);

        // Reset while shifting out byte 1: the row has shifted twice by then.
        preload(8'h44, 8'h33, 8'h22, 8'h11);
        clear_mon();
        start      = 1'b1;
        s_if.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("in_shift_before_reset", 32'(chain_en), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_valid", 32'(s_if.valid), 0);
        chk("midreset_chain_en", 32'(chain_en), 0);
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_cnt", 32'(dut4.cnt_q), 0);
        chk("midreset_data", 32'(s_if.data), 0);
        chk("midreset_last", 32'(s_if.last), 0);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        drain(-1, 0, -1, 1'b0);

        // Random contents, random ready and random start pulses while busy.
        for (int t = 0; t < 20; t++) begin
            preload(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            exp_from_model();
            drain(-1, 0, -1, 1'b1);
        end

        // Single-PE build.
        @(negedge clk);
        pre1  = 8'h5a;
        load1 = 1'b1;
        @(negedge clk);
        load1       = 1'b0;
        start1      = 1'b1;
        s1_if.ready = 1'b1;
        nb   = 0;
        ce1n = 0;
        dn1  = 0;
        fin1 = 1'b0;
        for (int c = 0; c < 20 && !fin1; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (s1_if.valid) begin
                nb++;
                chk("n1_data", 32'(s1_if.data), 32'h5a);
                chk("n1_last", 32'(s1_if.last), 1);
            end
            if (ce1) ce1n++;
            if (done1) begin
                dn1++;
                fin1 = 1'b1;
            end
        end
        chk("n1_completes", 32'(fin1), 1);
        chk("n1_bytes", nb, 1);
        chk("n1_chain_en_pulses", ce1n, 1);
        chk("n1_done_pulses", dn1, 1);
        chk("n1_row_cleared", 32'(chain1), 0);
        @(negedge clk);
        chk("n1_idle_after_done", 32'(busy1), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pe_drain_ctrl.md
Name: pe_drain_ctrl

Overview:
- Downstream readout stage for a row of PEs linked by their out_c/chain_in path.
- After compute finishes, it reads the accumulated results out of the tail PE one at a time and presents each byte on a valid/ready stream.
- It pulses the row's chain shift enable once per accepted byte and injects zeros at the head of the chain, so the row is cleared to zero when the drain completes.

Parameters:
- N_PE, 4, number of PEs in the chain (>=1).
- DATA_W, 8, accumulator/result width.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request a drain; sampled only in IDLE.
- busy  output  1  high in every state except IDLE. Top level holds load_weight low and gates compute while busy.
- done  output  1  one-cycle pulse when the drain completes.
- chain_en  output  1  drives chain_in_en of all PEs in the row.
- chain_head  output  DATA_W  drives chain_in of the head PE; constant 0.
- chain_tail  input  DATA_W  out_c of the tail PE.
- out_data  output  DATA_W  result byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts.
- out_last  output  1  qualifies the final byte (element index N_PE-1).

Behaviour:
- Reset (rst_n low at a clk edge):
  - state returns to IDLE; cnt is cleared to 0.
  - chain_en, out_valid, out_last, done and busy all go to 0; out_data goes to 0.
  - This applies mid-drain as well. The PEs keep whatever partial shift has already happened; no recovery is attempted.
- Registers: state, cnt (width max(1,$clog2(N_PE))), out_data, out_last, done. chain_en and out_valid are decoded from state.
- FSM states: IDLE, CAPTURE, VALID, SHIFT, DONE.
  - IDLE: start=1 moves to CAPTURE with cnt=0. start=0 stays in IDLE.
  - CAPTURE: out_data <= chain_tail; out_last <= (cnt==N_PE-1); move to VALID.
  - VALID: out_valid=1.
    - out_ready=1 moves to SHIFT.
    - Otherwise stay; out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - SHIFT: chain_en=1 for exactly this one cycle; the PEs shift on the closing edge.
    - If cnt==N_PE-1, move to DONE.
    - Otherwise cnt <= cnt+1 and move to CAPTURE.
  - DONE: done=1 for one cycle; move to IDLE; cnt <= 0.
- Output timing:
  - start sampled at edge E0 gives out_valid high after E1.
  - A handshake at edge Ek gives chain_en high during cycle k+1 and the next out_valid after Ek+2.
  - Minimum 3 cycles per byte.
  - done rises 2 cycles after the final handshake.
- Chain clearing:
  - Exactly N_PE chain_en pulses occur per drain, including one after the last byte.
  - With zeros injected at the head, every PE out_c equals 0 after DONE.
- Edge cases:
  - start while busy is ignored; it is not queued.
  - Handshake only in VALID; out_ready outside VALID has no effect.
  - chain_en is never high in IDLE, CAPTURE, VALID or DONE.
  - Results are emitted tail-first: byte 0 is the tail PE, byte N_PE-1 is the head PE.
  - N_PE=1: one byte with out_last=1 and one shift.
- No arithmetic is performed; values pass through unmodified at DATA_W bits.

Test Plan:
- Drain with ready always high.
  - Stimulus: N_PE=4, behavioural chain model preloaded head→tail 0x44,0x33,0x22,0x11; start pulse; out_ready=1.
  - Required: out_data sequence 0x11,0x22,0x33,0x44; out_last only on 0x44; exactly 4 chain_en pulses, each 1 cycle; done pulse 2 cycles after the last accept; model all zeros.
- Backpressure.
  - Stimulus: same preload; hold out_ready=0 for 5 cycles on byte 1.
  - Required: out_data stays 0x22 with out_valid=1; chain_en stays 0 during the stall; sequence otherwise unchanged.
- Start while busy.
  - Stimulus: pulse start again during byte 2.
  - Required: no restart; 4 bytes total; exactly one done pulse; busy drops after done.
- Reset mid-drain.
  - Stimulus: assert rst_n=0 for 1 cycle during SHIFT of byte 1.
  - Required: the following cycle, out_valid=0, chain_en=0, busy=0, cnt=0. A new start then drains the model's remaining shifted contents, beginning at CAPTURE.
- Latency check.
  - Stimulus: start at edge E0 with ready=1.
  - Required: out_valid high after E1; chain_en high in cycle 2; second out_valid high after E4.
- N_PE=1 build.
  - Stimulus: preload 0x5A; start.
  - Required: a single byte 0x5A with out_last=1; one chain_en pulse; done; model reads 0.
